// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Owns the PC, issues in-order word reads under a credit limit of QUEUE_DEPTH,
// buffers returned words in a small queue and presents {instr, pc} to decode.
// Redirects flush the queue and turn in-flight responses into drops.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky trap on misaligned
// redirect target); when undefined the target's low two bits are cleared.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misaligned
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int SW = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   last_pc_q;

  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [31:0]   q_pc    [QUEUE_DEPTH];

  logic [31:0]   redirect_target;
  logic          trap_active;
  logic [SW-1:0] inflight;
  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  assign redirect_target = redirect_pc;
  assign trap_active     = misalign_q;
  assign misaligned      = misalign_q;

  // Sticky trap: any redirect to a non-word-aligned target halts fetch until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign trap_active     = 1'b0;
  assign misaligned      = 1'b0;
`endif

  // Credits cover queued entries plus every response still to come back (kept or dropped),
  // so a returning word always has a free slot.
  assign inflight       = SW'(out_q) + SW'(drop_q) + SW'(count_q);
  assign credit_ok      = inflight < SW'(QUEUE_DEPTH);
  assign imem_req_valid = rst_n && credit_ok && !redirect_valid && !trap_active;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = (count_q != '0) && !trap_active;
  assign pop         = instr_valid && instr_ready;
  // A response is kept only when nothing is owed to drops and no redirect is flushing this cycle.
  assign push        = imem_rsp_valid && !redirect_valid && (drop_q == '0);

  // Next-state for PC, credit counters and queue pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect_valid) begin
      // Everything in flight becomes a drop; a response arriving now retires one of them.
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_d     = drop_q + out_q - CW'(imem_rsp_valid);
      out_d      = '0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        tail_d   = ptr_inc(tail_q);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      out_d   = out_q + CW'(req_fire) - CW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      last_pc_q  <= instr_pc;
    end
  end

  // Queue storage: kept responses are written at the tail with the PC they were fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail_q] <= imem_rsp_data;
      q_pc[tail_q]    <= rsp_pc_q;
    end
  end

  // Decode slot: head of queue, or NOP with the previously shown PC when empty.
  always_comb begin
    instr    = NOP;
    instr_pc = last_pc_q;
    if (instr_valid) begin
      instr    = q_instr[head_q];
      instr_pc = q_pc[head_q];
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(QUEUE_DEPTH))));

  credit_chk: assert property (@(posedge clk) disable iff (!rst_n)
    inflight <= SW'(QUEUE_DEPTH));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-cycle expectations for streaming
// and stall, plus hand sequences for redirects, async reset and misaligned targets.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int lat   = 1;

  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] acc_log   [$];
  logic [31:0] pop_pc    [$];
  logic [31:0] pop_ins   [$];

  typedef struct {
    logic        rdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl [23];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] addr,
                              input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.rdy = rdy; v.e_rv = rv; v.e_addr = addr; v.e_iv = iv; v.e_ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock: log handshakes, cross the edge, then model the memory response.
  task automatic advance();
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc_n + lat);
      acc_log.push_back(imem_req_addr);
      $display("cyc %0d: req accepted addr=%h", cyc_n, imem_req_addr);
    end
    if (instr_valid && instr_ready) begin
      pop_pc.push_back(instr_pc);
      pop_ins.push_back(instr);
      $display("cyc %0d: decode took pc=%h instr=%h", cyc_n, instr_pc, instr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    redirect_valid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic step();
    #1;
    advance();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    pend_addr.delete(); pend_due.delete();
    acc_log.delete(); pop_pc.delete(); pop_ins.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc_n = 0;
  endtask

  // Run with decode ready until two more instructions are taken, then check them.
  task automatic expect_pops(input logic [31:0] e0, input logic [31:0] e1);
    int base;
    int guard;
    base  = pop_pc.size();
    guard = 0;
    instr_ready = 1'b1;
    while (pop_pc.size() < base + 2 && guard < 40) begin
      step();
      guard++;
    end
    if (pop_pc.size() < base + 2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pop_timeout: got %0d pops required 2", pop_pc.size() - base);
    end else begin
      chk("pop0_pc",    pop_pc[base],      e0);
      chk("pop0_instr", pop_ins[base],     mem_word(e0));
      chk("pop1_pc",    pop_pc[base + 1],  e1);
      chk("pop1_instr", pop_ins[base + 1], mem_word(e1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n_acc;

    // Streaming with memory latency 1: credits allow two words per three cycles.
    tbl[0]  = mk(1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
    tbl[1]  = mk(1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
    tbl[2]  = mk(1'b1, 1'b0, 32'h08, 1'b1, 32'h00);
    tbl[3]  = mk(1'b1, 1'b1, 32'h08, 1'b1, 32'h04);
    tbl[4]  = mk(1'b1, 1'b1, 32'h0c, 1'b0, 32'h04);
    tbl[5]  = mk(1'b1, 1'b0, 32'h10, 1'b1, 32'h08);
    tbl[6]  = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h0c);
    tbl[7]  = mk(1'b1, 1'b1, 32'h14, 1'b0, 32'h0c);
    // Decode stalled for ten cycles: queue fills, requests stop.
    for (int i = 8; i < 18; i++) tbl[i] = mk(1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
    tbl[18] = mk(1'b1, 1'b0, 32'h18, 1'b1, 32'h10);
    tbl[19] = mk(1'b1, 1'b1, 32'h18, 1'b1, 32'h14);
    tbl[20] = mk(1'b1, 1'b1, 32'h1c, 1'b0, 32'h14);
    tbl[21] = mk(1'b1, 1'b0, 32'h20, 1'b1, 32'h18);
    tbl[22] = mk(1'b1, 1'b1, 32'h20, 1'b1, 32'h1c);

    // Reset values while reset is held, before any clock edge.
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr",  imem_req_addr,  32'h0);
    chk("rst_instr_valid", instr_valid,  1'b0);
    chk("rst_instr",     instr,          NOP);
    chk("rst_instr_pc",  instr_pc,       32'h0);
    chk("rst_misaligned", misaligned,    1'b0);

    // Table-driven streaming and stall.
    lat = 1;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      instr_ready = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d_req_valid", i),   imem_req_valid, tbl[i].e_rv);
      chk($sformatf("t%0d_req_addr", i),    imem_req_addr,  tbl[i].e_addr);
      chk($sformatf("t%0d_instr_valid", i), instr_valid,    tbl[i].e_iv);
      chk($sformatf("t%0d_instr_pc", i),    instr_pc,       tbl[i].e_ipc);
      chk($sformatf("t%0d_instr", i),       instr,
          tbl[i].e_iv ? mem_word(tbl[i].e_ipc) : NOP);
      advance();
    end

    // Stall from reset: exactly two requests accepted, then release in order.
    lat = 1;
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    #1;
    chk("stall_accepts", acc_log.size(), 2);
    chk("stall_req_valid", imem_req_valid, 1'b0);
    expect_pops(32'h0, 32'h4);
    expect_pops(32'h8, 32'hc);

    // Two requests outstanding at redirect: both responses dropped.
    lat = 3;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("redir_req_valid", imem_req_valid, 1'b0);
    base = acc_log.size();
    advance();
    expect_pops(32'h100, 32'h104);
    chk("redir_first_acc", acc_log[base], 32'h100);

    // Redirect coincident with a response and a decode pop.
    lat = 1;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    chk("coin_instr_valid", instr_valid, 1'b1);
    chk("coin_instr_pc",    instr_pc,    32'h0);
    advance();
    #1;
    chk("coin_next_iv",   instr_valid,    1'b0);
    chk("coin_next_rv",   imem_req_valid, 1'b1);
    chk("coin_next_addr", imem_req_addr,  32'h200);
    chk("coin_popped_once", pop_pc.size(), 1);
    expect_pops(32'h200, 32'h204);

    // Asynchronous reset between edges, mid-stream.
    lat = 1;
    do_reset();
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid",   imem_req_valid, 1'b0);
    chk("arst_req_addr",    imem_req_addr,  32'h0);
    chk("arst_instr_valid", instr_valid,    1'b0);
    chk("arst_instr",       instr,          NOP);
    chk("arst_instr_pc",    instr_pc,       32'h0);
    do_reset();
    #1;
    chk("arst_first_rv",   imem_req_valid, 1'b1);
    chk("arst_first_addr", imem_req_addr,  32'h0);
    expect_pops(32'h0, 32'h4);

    // Misaligned redirect target.
    lat = 1;
    do_reset();
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    chk("mis_redir_rv", imem_req_valid, 1'b0);
    base = acc_log.size();
    advance();
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("mis%0d_flag", i), misaligned,     1'b1);
      chk($sformatf("mis%0d_rv", i),   imem_req_valid, 1'b0);
      chk($sformatf("mis%0d_iv", i),   instr_valid,    1'b0);
      advance();
    end
    n_acc = acc_log.size() - base;
    chk("mis_no_accepts", n_acc, 0);
`else
    #1;
    chk("mis_flag", misaligned,    1'b0);
    chk("mis_addr", imem_req_addr, 32'h100);
    expect_pops(32'h100, 32'h104);
    n_acc = acc_log.size() - base;
    chk("mis_accepted", (n_acc > 0) ? acc_log[base] : 32'hFFFF_FFFF, 32'h100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
